// File: rtl/display_scanner_pkg.sv
// Shared clock-display definitions: digit count, segment widths and the
// digit-index type used by the multiplexed display scanner.
package display_scanner_pkg;

   localparam int DIGITS  = 5;
   localparam int SEG_W   = 8;
   localparam int FRAME_W = DIGITS * SEG_W;

   typedef logic [2:0] digit_idx_t;

   localparam digit_idx_t LAST_DIGIT = digit_idx_t'(DIGITS - 1);

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-N counter with enable; tc flags the enabled cycle on which the
// count wraps from N-1 back to 0.
module scan_prescaler #(
   parameter  int N = 2,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/display_scanner.sv
// Five-digit multiplexed seven-segment scanner with anti-ghost blanking,
// tear-free frame double buffering and per-digit blinking.
module display_scanner
   import display_scanner_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] frame,
   input  logic               frame_load,
   input  logic [DIGITS-1:0]  blink_mask,
   output logic [SEG_W-1:0]   seg,
   output logic [DIGITS-1:0]  an,
   output logic               frame_done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] BLANK_V = PW'(BLANK_CYC);

   logic [PW-1:0]                pcnt;
   logic                         slot_tc;
   logic [BW-1:0]                blink_cnt_unused;
   logic                         blink_tc;
   logic                         frame_wrap;
   logic                         wrap_q;
   digit_idx_t                   idx;
   logic [DIGITS-1:0][SEG_W-1:0] active_q;
   logic [FRAME_W-1:0]           pending_q;
   logic                         pending_valid;
   logic                         phase;
   logic [SEG_W-1:0]             seg_d;
   logic [DIGITS-1:0]            an_d;

   scan_prescaler #(.N(SCAN_DIV)) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .cnt (pcnt),
      .tc  (slot_tc)
   );

   assign frame_wrap = slot_tc && (idx == LAST_DIGIT);

   // Same counter type, stepped once per completed frame, paces the blink.
   scan_prescaler #(.N(BLINK_FRAMES)) u_blink (
      .clk (clk),
      .rst (rst),
      .en  (frame_wrap),
      .cnt (blink_cnt_unused),
      .tc  (blink_tc)
   );

   always_comb begin
      an_d  = '0;
      seg_d = '0;
      if (pcnt >= BLANK_V) begin
         an_d[idx] = 1'b1;
         if (!(phase && blink_mask[idx]))
            seg_d = active_q[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx           <= '0;
         active_q      <= '0;
         pending_q     <= '0;
         pending_valid <= 1'b0;
         phase         <= 1'b0;
         seg           <= '0;
         an            <= '0;
         wrap_q        <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         if (slot_tc)
            idx <= (idx == LAST_DIGIT) ? '0 : idx + 3'd1;

         // Active frame only changes between scans so a digit never tears;
         // a load landing on the wrap itself bypasses the pending buffer.
         if (frame_wrap) begin
            pending_valid <= 1'b0;
            if (frame_load)
               active_q <= frame;
            else if (pending_valid)
               active_q <= pending_q;
         end else if (frame_load) begin
            pending_q     <= frame;
            pending_valid <= 1'b1;
         end

         if (blink_tc)
            phase <= ~phase;

         seg        <= seg_d;
         an         <= an_d;
         wrap_q     <= frame_wrap;
         frame_done <= wrap_q;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner using an arithmetic reference model
// derived from elapsed cycles since reset and a log of frame loads.
module tb_display_scanner;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int BF = 2;
   localparam int FR = SD * 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] frame = '0;
   logic        frame_load = 1'b0;
   logic [4:0]  blink_mask = '0;
   logic [7:0]  seg;
   logic [4:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int ecount = 0;
   int          load_t[$];
   logic [39:0] load_d[$];
   logic [7:0]  exp_seg;
   logic [4:0]  exp_an;
   logic        exp_fd;

   always #5 clk = ~clk;

   display_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame      (frame),
      .frame_load (frame_load),
      .blink_mask (blink_mask),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   // State s = edges since reset release; outputs after that edge reflect s.
   // A frame shows whatever was loaded last before its scan began.
   function automatic void model(input int s);
      int p, idx, f;
      logic [39:0] act;
      logic phase;
      p   = s % SD;
      idx = (s / SD) % 5;
      f   = s / FR;
      act = '0;
      foreach (load_t[i]) if (load_t[i] < f * FR) act = load_d[i];
      phase   = ((f / BF) % 2) == 1;
      exp_an  = (p >= BC) ? 5'(1 << idx) : 5'b0;
      exp_seg = (p >= BC && !(phase && blink_mask[idx])) ? act[idx*8 +: 8] : 8'h00;
      exp_fd  = (s % FR == 0) && (s > 0);
   endfunction

   task automatic step(input logic ld, input logic [39:0] d);
      frame_load = ld;
      frame      = d;
      if (ld) begin
         load_t.push_back(ecount);
         load_d.push_back(d);
      end
      model(ecount);
      @(posedge clk);
      #1;
      ecount++;
      frame_load = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ecount = 0;
      load_t.delete();
      load_d.delete();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({seg, an, frame_done} !== 14'h0) begin
         errors++;
         $display("FAIL reset_state seg=%h an=%b fd=%b expected all zero", seg, an, frame_done);
      end
      do_reset();
      for (int i = 0; i < FR + 5; i++) begin
         step(1'b0, '0);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL reset_scan s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
   endtask

   task automatic test_basic();
      int last_fd;
      last_fd = -1;
      do_reset();
      step(1'b1, 40'h0504030201);
      for (int i = 0; i < 3 * FR; i++) begin
         step(1'b0, '0);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL basic_scan s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
         if (frame_done === 1'b1) begin
            if (last_fd >= 0) begin
               checks++;
               if (ecount - last_fd !== FR) begin
                  errors++;
                  $display("FAIL frame_done_period got %0d expected %0d", ecount - last_fd, FR);
               end
            end
            last_fd = ecount;
         end
      end
   endtask

   task automatic test_midload();
      while ((ecount / SD) % 5 != 2) step(1'b0, '0);
      step(1'b1, 40'hFFFFFFFFFF);
      for (int i = 0; i < 2 * FR; i++) begin
         step(1'b0, '0);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL midload s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic seen11;
      seen11 = 1'b0;
      while (ecount % FR != 1) step(1'b0, '0);
      step(1'b1, 40'h1111111111);
      step(1'b0, '0);
      step(1'b0, '0);
      step(1'b1, 40'h2222222222);
      for (int i = 0; i < 2 * FR; i++) begin
         step(1'b0, '0);
         if (seg === 8'h11) seen11 = 1'b1;
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL last_wins s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
      checks++;
      if (seen11 !== 1'b0) begin
         errors++;
         $display("FAIL overwritten_frame_seen got %b expected 0", seen11);
      end
   endtask

   task automatic test_wrap_load();
      while (ecount % FR != FR - 1) step(1'b0, '0);
      step(1'b1, 40'hAAAAAAAAAA);
      for (int i = 0; i < FR; i++) begin
         step(1'b0, '0);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL wrap_load s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
         if (i == BC) begin
            checks++;
            if ({seg, an} !== {8'hAA, 5'b00001}) begin
               errors++;
               $display("FAIL wrap_load_digit0 seg=%h an=%b expected seg=aa an=00001", seg, an);
            end
         end
      end
   endtask

   task automatic test_blink();
      int blanked;
      blanked = 0;
      step(1'b1, 40'h3C3C3C3C3C);
      blink_mask = 5'b00100;
      for (int i = 0; i < 9 * FR; i++) begin
         step(1'b0, '0);
         if (an[2] === 1'b1 && seg === 8'h00) blanked++;
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL blink s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
      checks++;
      if (blanked == 0) begin
         errors++;
         $display("FAIL blink_active blanked_cycles=%0d expected nonzero", blanked);
      end
      blink_mask = '0;
   endtask

   task automatic test_random();
      logic        ld;
      logic [39:0] d;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) blink_mask = 5'($urandom);
         ld = ($urandom_range(0, 7) == 0);
         d  = {8'($urandom), 32'($urandom)};
         step(ld, d);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL random s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
      blink_mask = '0;
   endtask

   task automatic test_rst_mid();
      while (!((ecount / SD) % 5 == 3 && ecount % SD == 2)) step(1'b0, '0);
      step(1'b1, 40'h7777777777);
      rst = 1'b1;
      #1;
      checks++;
      if ({seg, an, frame_done} !== 14'h0) begin
         errors++;
         $display("FAIL rst_async seg=%h an=%b fd=%b expected all zero", seg, an, frame_done);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({seg, an, frame_done} !== 14'h0) begin
         errors++;
         $display("FAIL rst_hold seg=%h an=%b fd=%b expected all zero", seg, an, frame_done);
      end
      rst = 1'b0;
      ecount = 0;
      load_t.delete();
      load_d.delete();
      for (int i = 0; i < 2 * FR; i++) begin
         step(1'b0, '0);
         checks++;
         if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL rst_restart s=%0d seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     ecount - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_midload();
      test_back_to_back();
      test_wrap_load();
      test_blink();
      test_random();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL take parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-002 SHALL take parameter BLANK_CYC, default 500: anti-ghost blank cycles at the start of each slot, less than SCAN_DIV.
REQ-003 SHALL take parameter BLINK_FRAMES, default 100: full scan frames per blink half-period, minimum 1.
REQ-004 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL provide port frame, input, 40: five 8-bit segment patterns; digit i = frame[8i+7:8i], digit 0 rightmost, bit=1 means segment lit.
REQ-007 SHALL provide port frame_load, input, 1: single-cycle strobe qualifying frame.
REQ-008 SHALL provide port blink_mask, input, 5: per-digit blink enable, sampled live.
REQ-009 SHALL provide port seg, output, 8: segment drive for the selected digit, active-high, registered.
REQ-010 SHALL provide port an, output, 5: digit enable, one-hot active-high or all-zero, registered.
REQ-011 SHALL provide port frame_done, output, 1: one-cycle pulse when digit 4's slot ends.

Function
REQ-012 SHALL keep a prescaler counting 0..SCAN_DIV-1; on terminal count it SHALL wrap to 0 and advance digit index 0->1->2->3->4->0.
REQ-013 SHALL drive an=0 and seg=0 while prescaler < BLANK_CYC; otherwise an[idx]=1 and seg = active digit idx pattern, subject to REQ-017.
REQ-014 SHALL register outputs with exactly one clock of latency after prescaler/index state.
REQ-015 SHALL capture frame on frame_load into a pending register and set pending_valid; a later frame_load before transfer overwrites pending (last wins).
REQ-016 SHALL copy pending to the active frame and clear pending_valid on the index 4->0 wrap cycle only, so no frame tears mid-scan; if frame_load coincides with that wrap, the newly presented frame SHALL go straight to active and pending_valid SHALL clear.
REQ-017 SHALL keep blink phase toggling after every BLINK_FRAMES completed frames; when phase=1 and blink_mask[idx]=1, seg SHALL be 0 while an still enables the digit.
REQ-018 SHALL assert frame_done for exactly one cycle, aligned with the first output cycle of the slot following digit 4.

Reset
REQ-019 SHALL clear to zero asynchronously on rst high: seg, an, frame_done, prescaler, index, active frame, pending frame, pending_valid, blink counter and phase.
REQ-020 SHALL hold all state during reset, ignore frame_load, and start in digit 0's blank interval on the first edge after deassertion; rst mid-scan discards pending data.

Structure
REQ-021 SHALL place DIGITS=5, SEG_W=8, FRAME_W=40 and the digit-index typedef in the shared clock-display package.
REQ-022 SHALL instantiate one sub-module, scan_prescaler: a parameterised modulo-N counter with terminal-count output, used for both slot timing and blink frame counting.

Verification (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-023 SHALL cover reset then load 0x0504030201: an sequence 00000,00001x3,00000,00010x3 ... 10000x3; seg 01,02,03,04,05 in lit cycles; frame_done each 20 cycles.
REQ-024 SHALL cover loading 0xFFFFFFFFFF while digit 2 is displayed: digits 2-4 still show old values; the next frame shows FF on all digits.
REQ-025 SHALL cover two loads (0x11.., then 0x22..) in one frame: only 0x22 patterns appear, with no 0x11 at any point.
REQ-026 SHALL cover frame_load asserted on the wrap cycle with 0xAA..: digit 0 of the immediately following slot shows AA.
REQ-027 SHALL cover blink_mask=00100: digit 2's seg is 0 in frames 3-4, 7-8 ... while an[2] still pulses; other digits are unaffected.
REQ-028 SHALL cover rst pulsed for 1 cycle mid-slot of digit 3: an=0 and seg=0 immediately, then the scan restarts at digit 0 with an all-zero pattern until the next load.
